// File: rtl/forward_transform_quant_pkg.sv
// rtl/forward_transform_quant_pkg.sv - shared types, tables and QP helpers for the forward transform/quant block
package forward_transform_quant_pkg;

    typedef enum logic [1:0] {
        FWD_IDLE,
        FWD_ROW,
        FWD_COL,
        FWD_DONE
    } fwd_state_t;

    typedef enum logic [1:0] {
        QCLASS_A,
        QCLASS_B,
        QCLASS_C
    } quant_class_t;

    localparam logic [5:0] QP_MAX     = 6'd51;
    localparam int         QBITS_BASE = 15;

    localparam logic [13:0] MF_A [6] = '{14'd13107, 14'd11916, 14'd10082, 14'd9362, 14'd8192, 14'd7282};
    localparam logic [13:0] MF_B [6] = '{14'd5243,  14'd4660,  14'd4194,  14'd3647, 14'd3355, 14'd2893};
    localparam logic [13:0] MF_C [6] = '{14'd8066,  14'd7490,  14'd6554,  14'd5825, 14'd5243, 14'd4559};

    // Inverse zigzag: raster index (4*row+col) -> scan slot
    localparam logic [3:0] ZZ_SLOT [16] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd2, 4'd4, 4'd7, 4'd12,
                                            4'd3, 4'd8, 4'd11, 4'd13, 4'd9, 4'd10, 4'd14, 4'd15};

    function automatic logic [3:0] qp_div6(input logic [5:0] qp);
        return 4'(qp / 6'd6);
    endfunction

    function automatic logic [2:0] qp_mod6(input logic [5:0] qp);
        return 3'(qp % 6'd6);
    endfunction

    function automatic quant_class_t quant_class(input logic [1:0] row, input logic [1:0] col);
        if (!row[0] && !col[0]) return QCLASS_A;
        else if (row[0] && col[0]) return QCLASS_B;
        else return QCLASS_C;
    endfunction

    function automatic logic [13:0] mf_lookup(input logic [2:0] mod6, input quant_class_t cls);
        case (cls)
            QCLASS_A: return MF_A[mod6];
            QCLASS_B: return MF_B[mod6];
            default:  return MF_C[mod6];
        endcase
    endfunction

    function automatic logic [3:0] zz_slot(input logic [3:0] raster);
        return ZZ_SLOT[raster];
    endfunction

endpackage

// File: rtl/forward_quant_unit.sv
// rtl/forward_quant_unit.sv - combinational forward quantiser for one transform coefficient
module forward_quant_unit
    import forward_transform_quant_pkg::*;
#(
    parameter int INT_W   = 16,
    parameter int COEFF_W = 16
) (
    input  logic signed [INT_W-1:0]   w,
    input  logic        [3:0]         qp_div6,
    input  logic        [2:0]         qp_mod6,
    input  quant_class_t              cls,
    input  logic                      intra,
    output logic signed [COEFF_W-1:0] z
);

    localparam int PROD_W = 28;

    logic [INT_W-1:0]  mag;
    logic [4:0]        qbits;
    logic [PROD_W-1:0] f;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] level;

    // Sign is reapplied after rounding so that a zero level never comes out negative
    always_comb begin
        qbits = 5'(QBITS_BASE) + 5'(qp_div6);
        mag   = w[INT_W-1] ? $unsigned(-w) : $unsigned(w);
        f     = intra ? PROD_W'((PROD_W'(1) << qbits) / PROD_W'(3))
                      : PROD_W'((PROD_W'(1) << qbits) / PROD_W'(6));
        prod  = PROD_W'(mag) * PROD_W'(mf_lookup(qp_mod6, cls)) + f;
        level = prod >> qbits;
        z     = w[INT_W-1] ? -$signed(COEFF_W'(level)) : $signed(COEFF_W'(level));
    end

endmodule

// File: rtl/forward_transform_quant.sv
// rtl/forward_transform_quant.sv - iterative 4x4 forward core transform, quantisation and zigzag scan
module forward_transform_quant
    import forward_transform_quant_pkg::*;
#(
    parameter int IN_W    = 9,
    parameter int INT_W   = 16,
    parameter int COEFF_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      start,
    output logic                      ready,
    input  logic [5:0]                QP,
    input  logic                      intra,
    input  logic signed [IN_W-1:0]    residual_in_0,  residual_in_1,  residual_in_2,  residual_in_3,
    input  logic signed [IN_W-1:0]    residual_in_4,  residual_in_5,  residual_in_6,  residual_in_7,
    input  logic signed [IN_W-1:0]    residual_in_8,  residual_in_9,  residual_in_10, residual_in_11,
    input  logic signed [IN_W-1:0]    residual_in_12, residual_in_13, residual_in_14, residual_in_15,
    output logic signed [COEFF_W-1:0] coeff_0,  coeff_1,  coeff_2,  coeff_3,
    output logic signed [COEFF_W-1:0] coeff_4,  coeff_5,  coeff_6,  coeff_7,
    output logic signed [COEFF_W-1:0] coeff_8,  coeff_9,  coeff_10, coeff_11,
    output logic signed [COEFF_W-1:0] coeff_12, coeff_13, coeff_14, coeff_15,
    output logic [4:0]                TotalCoeff,
    output logic                      valid
);

    fwd_state_t state, state_nxt;
    logic [1:0] cnt;
    logic       accept;
    logic [5:0] qp_l;
    logic       intra_l;
    logic [4:0] total_r;
    logic [2:0] nz_cnt;

    logic signed [IN_W-1:0]    res_in  [16];
    logic signed [IN_W-1:0]    res_l   [16];
    logic signed [INT_W-1:0]   temp    [4][4];
    logic signed [INT_W-1:0]   bx      [4];
    logic signed [INT_W-1:0]   y       [4];
    logic signed [INT_W-1:0]   s0, s1, d0, d1;
    logic signed [COEFF_W-1:0] z       [4];
    logic signed [COEFF_W-1:0] coeff_r [16];
    quant_class_t              cls     [4];

    assign res_in[0]  = residual_in_0;   assign res_in[1]  = residual_in_1;
    assign res_in[2]  = residual_in_2;   assign res_in[3]  = residual_in_3;
    assign res_in[4]  = residual_in_4;   assign res_in[5]  = residual_in_5;
    assign res_in[6]  = residual_in_6;   assign res_in[7]  = residual_in_7;
    assign res_in[8]  = residual_in_8;   assign res_in[9]  = residual_in_9;
    assign res_in[10] = residual_in_10;  assign res_in[11] = residual_in_11;
    assign res_in[12] = residual_in_12;  assign res_in[13] = residual_in_13;
    assign res_in[14] = residual_in_14;  assign res_in[15] = residual_in_15;

    assign coeff_0  = coeff_r[0];   assign coeff_1  = coeff_r[1];
    assign coeff_2  = coeff_r[2];   assign coeff_3  = coeff_r[3];
    assign coeff_4  = coeff_r[4];   assign coeff_5  = coeff_r[5];
    assign coeff_6  = coeff_r[6];   assign coeff_7  = coeff_r[7];
    assign coeff_8  = coeff_r[8];   assign coeff_9  = coeff_r[9];
    assign coeff_10 = coeff_r[10];  assign coeff_11 = coeff_r[11];
    assign coeff_12 = coeff_r[12];  assign coeff_13 = coeff_r[13];
    assign coeff_14 = coeff_r[14];  assign coeff_15 = coeff_r[15];

    assign ready      = (state == FWD_IDLE);
    assign valid      = (state == FWD_DONE);
    assign TotalCoeff = total_r;
    assign accept     = ena && start && (state == FWD_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            FWD_IDLE: if (start)         state_nxt = FWD_ROW;
            FWD_ROW:  if (cnt == 2'd3)   state_nxt = FWD_COL;
            FWD_COL:  if (cnt == 2'd3)   state_nxt = FWD_DONE;
            FWD_DONE:                    state_nxt = FWD_IDLE;
            default:                     state_nxt = FWD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FWD_IDLE;
            cnt   <= 2'd0;
        end else if (ena) begin
            state <= state_nxt;
            cnt   <= (state == FWD_ROW || state == FWD_COL) ? cnt + 2'd1 : 2'd0;
        end
    end

    // ROW feeds a latched residual row; COL feeds the row results gathered for one column
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            if (state == FWD_COL)
                bx[k] = temp[cnt][k];
            else
                bx[k] = INT_W'(res_l[{cnt, 2'(k)}]);
        end
        s0   = bx[0] + bx[3];
        s1   = bx[1] + bx[2];
        d0   = bx[0] - bx[3];
        d1   = bx[1] - bx[2];
        y[0] = s0 + s1;
        y[1] = (d0 <<< 1) + d1;
        y[2] = s0 - s1;
        y[3] = d0 - (d1 <<< 1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_quant
            assign cls[gi] = quant_class(2'(gi), cnt);
            forward_quant_unit #(
                .INT_W   (INT_W),
                .COEFF_W (COEFF_W)
            ) u_quant (
                .w       (y[gi]),
                .qp_div6 (qp_div6(qp_l)),
                .qp_mod6 (qp_mod6(qp_l)),
                .cls     (cls[gi]),
                .intra   (intra_l),
                .z       (z[gi])
            );
        end
    endgenerate

    always_comb begin
        nz_cnt = 3'd0;
        for (int i = 0; i < 4; i++)
            nz_cnt = nz_cnt + 3'(z[i] != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qp_l    <= 6'd0;
            intra_l <= 1'b0;
            total_r <= 5'd0;
            for (int k = 0; k < 16; k++) begin
                res_l[k]   <= '0;
                coeff_r[k] <= '0;
            end
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    temp[i][j] <= '0;
        end else if (ena) begin
            if (accept) begin
                qp_l    <= (QP > QP_MAX) ? QP_MAX : QP;
                intra_l <= intra;
                total_r <= 5'd0;
                for (int k = 0; k < 16; k++)
                    res_l[k] <= res_in[k];
            end
            if (state == FWD_ROW) begin
                for (int i = 0; i < 4; i++)
                    temp[i][cnt] <= y[i];
            end
            if (state == FWD_COL) begin
                for (int i = 0; i < 4; i++)
                    coeff_r[zz_slot({2'(i), cnt})] <= z[i];
                total_r <= total_r + 5'(nz_cnt);
            end
        end
    end

endmodule

// File: tb/tb_forward_transform_quant.sv
// tb/tb_forward_transform_quant.sv - randomized self-checking bench against a matrix-level reference model
module tb_forward_transform_quant;

    logic              clk = 1'b0;
    logic              rst, ena, start, intra;
    logic [5:0]        QP;
    logic              ready, valid;
    logic [4:0]        TotalCoeff;
    logic signed [8:0] res_drv [16];
    logic signed [15:0] coeff  [16];

    int n_vec  = 0;
    int n_miss = 0;

    int cm [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
    int mfa [6] = '{13107, 11916, 10082, 9362, 8192, 7282};
    int mfb [6] = '{5243, 4660, 4194, 3647, 3355, 2893};
    int mfc [6] = '{8066, 7490, 6554, 5825, 5243, 4559};
    int zz [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

    longint exp_coeff [16];
    int     exp_tc;

    always #5 clk = ~clk;

    forward_transform_quant dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .ready(ready), .QP(QP), .intra(intra),
        .residual_in_0(res_drv[0]),   .residual_in_1(res_drv[1]),   .residual_in_2(res_drv[2]),
        .residual_in_3(res_drv[3]),   .residual_in_4(res_drv[4]),   .residual_in_5(res_drv[5]),
        .residual_in_6(res_drv[6]),   .residual_in_7(res_drv[7]),   .residual_in_8(res_drv[8]),
        .residual_in_9(res_drv[9]),   .residual_in_10(res_drv[10]), .residual_in_11(res_drv[11]),
        .residual_in_12(res_drv[12]), .residual_in_13(res_drv[13]), .residual_in_14(res_drv[14]),
        .residual_in_15(res_drv[15]),
        .coeff_0(coeff[0]),   .coeff_1(coeff[1]),   .coeff_2(coeff[2]),   .coeff_3(coeff[3]),
        .coeff_4(coeff[4]),   .coeff_5(coeff[5]),   .coeff_6(coeff[6]),   .coeff_7(coeff[7]),
        .coeff_8(coeff[8]),   .coeff_9(coeff[9]),   .coeff_10(coeff[10]), .coeff_11(coeff[11]),
        .coeff_12(coeff[12]), .coeff_13(coeff[13]), .coeff_14(coeff[14]), .coeff_15(coeff[15]),
        .TotalCoeff(TotalCoeff), .valid(valid)
    );

    task automatic check_value(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: W = C*X*C^T by plain matrix products, then quantise and scan
    task automatic compute_model();
        int     q, qb, m, w, mf;
        longint f, mag, lvl;
        longint zr [16];
        q  = (int'(QP) > 51) ? 51 : int'(QP);
        qb = 15 + q / 6;
        m  = q % 6;
        f  = intra ? (longint'(1) << qb) / 3 : (longint'(1) << qb) / 6;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                w = 0;
                for (int k = 0; k < 4; k++)
                    for (int l = 0; l < 4; l++)
                        w += cm[i][k] * int'(res_drv[4*k+l]) * cm[j][l];
                if (i % 2 == 0 && j % 2 == 0)      mf = mfa[m];
                else if (i % 2 == 1 && j % 2 == 1) mf = mfb[m];
                else                               mf = mfc[m];
                mag = (w < 0) ? -w : w;
                lvl = (mag * mf + f) >> qb;
                zr[4*i+j] = (w < 0) ? -lvl : lvl;
            end
        end
        exp_tc = 0;
        for (int k = 0; k < 16; k++) begin
            exp_coeff[k] = zr[zz[k]];
            if (exp_coeff[k] != 0) exp_tc++;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 16; k++)
            check_value($sformatf("%s coeff_%0d", tag, k), coeff[k], exp_coeff[k]);
        check_value({tag, " TotalCoeff"}, TotalCoeff, exp_tc);
    endtask

    task automatic run_block(input string tag, input int stall_at, input int stall_len,
                             input int restart_at, input bit hold_done);
        int lat;
        compute_model();
        check_value({tag, " ready before start"}, ready, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        while (valid !== 1'b1 && lat < 40) begin
            start = (lat == restart_at);
            if (lat == restart_at)
                for (int k = 0; k < 16; k++) res_drv[k] = 9'(int'($urandom_range(0, 510)) - 255);
            ena = !(lat >= stall_at && lat < stall_at + stall_len);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        ena   = 1'b1;
        check_value({tag, " latency"}, lat, 8 + stall_len);
        check_outputs(tag);
        if (hold_done) begin
            ena = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check_value({tag, " valid held while stalled"}, valid, 1);
            ena = 1'b1;
        end
        @(posedge clk); #1;
        check_value({tag, " valid pulse ends"}, valid, 0);
        check_value({tag, " ready after done"}, ready, 1);
        check_outputs({tag, " hold"});
    endtask

    task automatic fill_res(input int v);
        for (int k = 0; k < 16; k++) res_drv[k] = 9'(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ena = 1'b1; start = 1'b0; intra = 1'b0; QP = 6'd0;
        fill_res(0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_value("reset ready", ready, 1);
        check_value("reset valid", valid, 0);
        check_value("reset TotalCoeff", TotalCoeff, 0);
        check_value("reset coeff_0", coeff[0], 0);

        fill_res(0); QP = 6'd28; intra = 1'b1;
        run_block("t1 zero", -1, 0, -1, 1'b1);

        fill_res(10); QP = 6'd0; intra = 1'b1;
        run_block("t2 dc+", -1, 0, -1, 1'b0);
        check_value("t2 hand coeff_0", coeff[0], 64);
        check_value("t2 hand TotalCoeff", TotalCoeff, 1);

        fill_res(-10);
        run_block("t3 dc-", -1, 0, -1, 1'b0);
        check_value("t3 hand coeff_0", coeff[0], -64);

        fill_res(0); res_drv[0] = 9'sd255; QP = 6'd0; intra = 1'b0;
        run_block("t4 impulse", -1, 0, -1, 1'b0);
        check_value("t4 hand coeff_0", coeff[0], 102);
        check_value("t4 hand coeff_1", coeff[1], 125);
        check_value("t4 hand coeff_4", coeff[4], 163);
        check_value("t4 hand TotalCoeff", TotalCoeff, 16);

        fill_res(0); res_drv[0] = 9'sd255;
        run_block("t5 stall", 1, 3, -1, 1'b0);
        check_value("t5 hand coeff_4", coeff[4], 163);

        for (int k = 0; k < 16; k++) res_drv[k] = 9'(int'($urandom_range(0, 510)) - 255);
        QP = 6'd20; intra = 1'b1;
        run_block("t6 restart", -1, 0, 2, 1'b0);

        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check_value("rst beats start ready", ready, 1);

        for (int k = 0; k < 16; k++) res_drv[k] = 9'(int'($urandom_range(0, 510)) - 255);
        QP = 6'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_value("abort ready", ready, 1);
        check_value("abort valid", valid, 0);
        check_value("abort TotalCoeff", TotalCoeff, 0);
        for (int k = 0; k < 16; k++)
            check_value($sformatf("abort coeff_%0d", k), coeff[k], 0);

        for (int n = 0; n < 30; n++) begin
            int sa, sl;
            for (int k = 0; k < 16; k++) res_drv[k] = 9'(int'($urandom_range(0, 510)) - 255);
            QP    = 6'($urandom_range(0, 63));
            intra = 1'($urandom_range(0, 1));
            sa    = int'($urandom_range(0, 7));
            sl    = (n % 3 == 0) ? int'($urandom_range(1, 3)) : 0;
            run_block($sformatf("rand%0d", n), sa, sl, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
